reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file plus rename/busy table for the Tomasulo core.
- Sits at the receiving end of the ROB commit port: it consumes `reg_write`/`reg_rd`/`reg_val`/`commit_rob_pos` and `rollback`.
- On issue, the decoder renames `rd` to the allocated ROB slot.
- The decoder reads source operands as either a committed value or a producing ROB position.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- REG_POS_W, 5, register index width (`` `REG_POS_WID``).
- ROB_POS_W, 4, ROB slot tag width (`` `ROB_POS_WID``, ROB_SIZE 16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  flush from ROB (mispredict)
- issue  in  1  decoder issues an instruction this cycle
- issue_rd  in  REG_POS_W  destination register of issued instruction
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to it
- rs1_idx  in  REG_POS_W  source-1 index (decoder)
- rs2_idx  in  REG_POS_W  source-2 index
- rs1_busy  out  1  source-1 value pending in ROB
- rs1_val  out  32  committed source-1 value (valid when !rs1_busy)
- rs1_rob_pos  out  ROB_POS_W  producer tag (valid when rs1_busy)
- rs2_busy, rs2_val, rs2_rob_pos  out  1/32/ROB_POS_W  same for source 2
- reg_write  in  1  ROB commit writes a register
- reg_rd  in  REG_POS_W  commit destination
- reg_val  in  32  commit value
- commit_rob_pos  in  ROB_POS_W  ROB slot being committed

Behaviour:
- Reset is synchronous and active-high, on `posedge clk`. It applies when `rst` is high, regardless of `rdy`.
- On reset: all regs=0, busy=0, tag=0.
- Reads are combinational and carry no outputs to reset. With `rst` high, outputs reflect the post-reset state from the next cycle.
- `rdy`=0 with `rst`=0: no state change; read outputs remain valid.
- x0: never written, never marked busy. Reads return busy=0, val=0, rob_pos=0.
- Commit write (`reg_write` && `reg_rd`!=0): `regs[reg_rd]<=reg_val` unconditionally.
  - `busy[reg_rd]` is cleared only if `tag[reg_rd]==commit_rob_pos`. A younger rename stays busy.
- Issue (`issue` && `issue_rd`!=0 && !`rollback`): `busy[issue_rd]<=1`, `tag[issue_rd]<=issue_rob_pos`.
- Issue with `issue_rd`=0 (stores, branches): no table change.
- Simultaneous commit and issue to the same rd: the value write happens, and issue wins busy/tag (busy=1, tag=issue_rob_pos).
- Rollback cycle:
  - The commit value write still applies (JALR commits and rolls back in the same cycle).
  - All busy bits are cleared. Tags and values are otherwise retained.
  - Any issue is ignored.
- Read bypass, per source i:
  - If busy[idx] && `reg_write` && `reg_rd`==idx && `tag[idx]`==`commit_rob_pos`, then rs_busy=0 and rs_val=`reg_val`.
  - Else if busy: rs_busy=1, rs_rob_pos=tag.
  - Else: rs_busy=0, rs_val=regs[idx].
  - No bypass from same-cycle issue. The decoder reads before its own rename; rd==rs for the same instruction must report the OLD mapping.
- Latency: writes visible via bypass in the same cycle, via the array the next cycle.
- rs1/rs2 identical-index reads must return identical results.

Decomposition:
- Shared defines in Mydefine.v: `` `REG_POS_WID``, `` `ROB_POS_WID``, `` `ROB_SIZE``, `` `REG_NUM``.
- No separate typedefs needed.
- Single module. The per-source bypass mux is a small function/generate instance duplicated for rs1/rs2; no sub-module.

Test Plan:
- Reset then read x5 -> busy=0, val=0; read x0 after commit x0=0xDEAD -> val=0, busy=0.
- Issue rd=3 rob_pos=7; next cycle read x3 -> busy=1, rob_pos=7.
  - Then commit rd=3 pos=7 val=0x1234: same-cycle read -> busy=0, val=0x1234; next cycle array val=0x1234, busy=0.
- Issue rd=4 pos=2, then issue rd=4 pos=5, then commit rd=4 pos=2 val=0x11 -> x4 stays busy tag=5, stored val=0x11.
- Same cycle: commit rd=6 pos=1 val=0x22 and issue rd=6 pos=9 -> x6 busy, tag=9, stored val=0x22.
- Busy x1,x2,x8, then rollback with JALR commit rd=1 val=0x80 and issue rd=10 -> all busy=0, x1=0x80, x10 not busy.
- `rdy`=0 with issue and `reg_write` asserted -> no state change. `rst`=1 while `rdy`=0 -> state cleared next cycle.

Source files
------------

// File: rtl/reg_file_rename_pkg.sv
// Shared widths and helpers for the architectural register file and rename table.
package reg_file_rename_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_POS_W = 5;
  localparam int ROB_POS_W = 4;
  localparam int ROB_SIZE  = 16;
  localparam int DATA_W    = 32;

  typedef logic [REG_POS_W-1:0] reg_pos_t;
  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [DATA_W-1:0]    data_t;

  // Operand as seen by the decoder: either a committed value or the producing ROB slot.
  typedef struct packed {
    logic     busy;
    rob_pos_t rob_pos;
    data_t    val;
  } src_read_t;

  // x0 is hardwired zero and never takes part in renaming.
  function automatic logic is_arch_reg(input reg_pos_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file with rename/busy table: committed values from the ROB,
// renames from the decoder, combinational operand reads with commit bypass.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_idx,
  input  logic [REG_POS_W-1:0] rs2_idx,
  output logic                 rs1_busy,
  output logic [DATA_W-1:0]    rs1_val,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic                 rs2_busy,
  output logic [DATA_W-1:0]    rs2_val,
  output logic [ROB_POS_W-1:0] rs2_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos
);

  data_t              regs [REG_NUM];
  rob_pos_t           tag  [REG_NUM];
  logic [REG_NUM-1:0] busy;

  src_read_t rd1, rd2;

  // NOTE: the arrays are cleared on reset because the table must start with every
  // register committed and zero; this forces flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every reader sees
        // the pre-edge value regardless of statement order.
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy <= '0;
    end else if (rdy) begin
      if (reg_write && is_arch_reg(reg_rd)) begin
        regs[reg_rd] <= reg_val;
        // A younger rename of the same register keeps it busy.
        if (tag[reg_rd] == commit_rob_pos) busy[reg_rd] <= 1'b0;
      end
      // Later assignments win: rollback flushes everything, issue beats a same-rd commit.
      if (rollback) begin
        busy <= '0;
      end else if (issue && is_arch_reg(issue_rd)) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  // Reads see committed state plus a bypass of the commit landing this cycle;
  // a same-cycle issue is deliberately invisible so rd==rs reports the old mapping.
  function automatic src_read_t read_src(input reg_pos_t idx);
    src_read_t r;
    r.busy    = 1'b0;
    r.rob_pos = tag[idx];
    r.val     = regs[idx];
    if (busy[idx]) begin
      if (reg_write && reg_rd == idx && tag[idx] == commit_rob_pos) r.val = reg_val;
      else r.busy = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every combinational output is assigned on all paths (here via the function's
    // defaults) so no latch is inferred.
    rd1 = read_src(rs1_idx);
    rd2 = read_src(rs2_idx);
  end

  assign rs1_busy    = rd1.busy;
  assign rs1_val     = rd1.val;
  assign rs1_rob_pos = rd1.rob_pos;
  assign rs2_busy    = rd2.busy;
  assign rs2_val     = rd2.val;
  assign rs2_rob_pos = rd2.rob_pos;

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, rdy, rollback, issue, reg_write;
  logic [REG_POS_W-1:0] issue_rd, rs1_idx, rs2_idx, reg_rd;
  logic [ROB_POS_W-1:0] issue_rob_pos, commit_rob_pos;
  logic [DATA_W-1:0]    reg_val;
  logic                 rs1_busy, rs2_busy;
  logic [DATA_W-1:0]    rs1_val, rs2_val;
  logic [ROB_POS_W-1:0] rs1_rob_pos, rs2_rob_pos;

  int checks_total  = 0;
  int checks_passed = 0;

  // Behavioural model: committed values, pending flag and producer tag per register.
  logic [DATA_W-1:0]    m_val  [REG_NUM];
  logic                 m_pend [REG_NUM];
  logic [ROB_POS_W-1:0] m_prod [REG_NUM];

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
    .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; reg_write = 1'b0;
    issue_rd = '0; issue_rob_pos = '0; reg_rd = '0; reg_val = '0; commit_rob_pos = '0;
  endtask

  // Expected read for one source, straight from the operand-read rules.
  task automatic compare_src(input string name, input logic [REG_POS_W-1:0] idx,
                             input logic g_busy, input logic [DATA_W-1:0] g_val,
                             input logic [ROB_POS_W-1:0] g_pos);
    logic                 e_busy;
    logic [DATA_W-1:0]    e_val;
    if (idx == 0) begin
      check({name, " x0 busy"}, 64'(g_busy), 64'd0);
      check({name, " x0 val"},  64'(g_val),  64'd0);
      check({name, " x0 pos"},  64'(g_pos),  64'd0);
      return;
    end
    if (m_pend[idx] && reg_write && reg_rd == idx && m_prod[idx] == commit_rob_pos) begin
      e_busy = 1'b0; e_val = reg_val;
    end else begin
      e_busy = m_pend[idx]; e_val = m_val[idx];
    end
    check({name, " busy"}, 64'(g_busy), 64'(e_busy));
    if (e_busy) check({name, " rob_pos"}, 64'(g_pos), 64'(m_prod[idx]));
    else        check({name, " val"},     64'(g_val), 64'(e_val));
  endtask

  task automatic compare_model();
    if (rst) return;
    compare_src("rs1", rs1_idx, rs1_busy, rs1_val, rs1_rob_pos);
    compare_src("rs2", rs2_idx, rs2_busy, rs2_val, rs2_rob_pos);
  endtask

  // Settle after the falling-edge drive, then compare against the model.
  task automatic peek();
    #1;
    compare_model();
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_val[i] = '0; m_pend[i] = 1'b0; m_prod[i] = '0;
      end
    end else if (rdy) begin
      if (reg_write && reg_rd != 0) begin
        m_val[reg_rd] = reg_val;
        if (m_prod[reg_rd] == commit_rob_pos) m_pend[reg_rd] = 1'b0;
      end
      if (rollback) begin
        for (int i = 0; i < REG_NUM; i++) m_pend[i] = 1'b0;
      end else if (issue && issue_rd != 0) begin
        m_pend[issue_rd] = 1'b1;
        m_prod[issue_rd] = issue_rob_pos;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic expect_rs1(input string name, input logic busy_e,
                            input logic [DATA_W-1:0] val_e, input logic [ROB_POS_W-1:0] pos_e);
    check({name, " busy"}, 64'(rs1_busy), 64'(busy_e));
    if (busy_e) check({name, " rob_pos"}, 64'(rs1_rob_pos), 64'(pos_e));
    else        check({name, " val"},     64'(rs1_val),     64'(val_e));
  endtask

  task automatic expect_rs2(input string name, input logic busy_e,
                            input logic [DATA_W-1:0] val_e, input logic [ROB_POS_W-1:0] pos_e);
    check({name, " busy"}, 64'(rs2_busy), 64'(busy_e));
    if (busy_e) check({name, " rob_pos"}, 64'(rs2_rob_pos), 64'(pos_e));
    else        check({name, " val"},     64'(rs2_val),     64'(val_e));
  endtask

  initial begin
    idle_inputs();
    rs1_idx = '0; rs2_idx = '0;
    rst = 1'b1;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    rs1_idx = 5'd5; rs2_idx = 5'd0;
    peek(); expect_rs1("reset x5", 1'b0, 32'h0, 4'd0);
    tick();

    reg_write = 1'b1; reg_rd = 5'd0; reg_val = 32'hDEAD; rs1_idx = 5'd0;
    peek(); expect_rs1("x0 during commit", 1'b0, 32'h0, 4'd0);
    tick(); idle_inputs();
    peek(); expect_rs1("x0 after commit", 1'b0, 32'h0, 4'd0);

    issue = 1'b1; issue_rd = 5'd3; issue_rob_pos = 4'd7; rs1_idx = 5'd3;
    peek(); expect_rs1("rd==rs old mapping", 1'b0, 32'h0, 4'd0);
    tick(); idle_inputs(); rs2_idx = 5'd3;
    peek(); expect_rs1("x3 renamed", 1'b1, 32'h0, 4'd7);
    expect_rs2("x3 renamed rs2", 1'b1, 32'h0, 4'd7);

    reg_write = 1'b1; reg_rd = 5'd3; commit_rob_pos = 4'd7; reg_val = 32'h1234;
    peek(); expect_rs1("x3 bypass", 1'b0, 32'h1234, 4'd0);
    tick(); idle_inputs();
    peek(); expect_rs1("x3 committed", 1'b0, 32'h1234, 4'd0);

    issue = 1'b1; issue_rd = 5'd4; issue_rob_pos = 4'd2; peek(); tick();
    issue_rob_pos = 4'd5; peek(); tick(); idle_inputs();
    reg_write = 1'b1; reg_rd = 5'd4; commit_rob_pos = 4'd2; reg_val = 32'h11; rs1_idx = 5'd4;
    peek(); expect_rs1("x4 stale commit no bypass", 1'b1, 32'h0, 4'd5);
    tick(); idle_inputs();
    peek(); expect_rs1("x4 younger rename", 1'b1, 32'h0, 4'd5);

    reg_write = 1'b1; reg_rd = 5'd6; commit_rob_pos = 4'd1; reg_val = 32'h22;
    issue = 1'b1; issue_rd = 5'd6; issue_rob_pos = 4'd9; rs1_idx = 5'd6;
    peek(); tick(); idle_inputs();
    peek(); expect_rs1("x6 issue wins", 1'b1, 32'h0, 4'd9);

    issue = 1'b1;
    issue_rd = 5'd1; issue_rob_pos = 4'd3; peek(); tick();
    issue_rd = 5'd2; issue_rob_pos = 4'd4; peek(); tick();
    issue_rd = 5'd8; issue_rob_pos = 4'd6; peek(); tick();
    rollback = 1'b1; reg_write = 1'b1; reg_rd = 5'd1; reg_val = 32'h80; commit_rob_pos = 4'd3;
    issue_rd = 5'd10; issue_rob_pos = 4'd11; rs1_idx = 5'd1; rs2_idx = 5'd10;
    peek(); expect_rs1("jalr bypass", 1'b0, 32'h80, 4'd0);
    tick(); idle_inputs();
    peek(); expect_rs1("x1 after rollback", 1'b0, 32'h80, 4'd0);
    expect_rs2("x10 not renamed", 1'b0, 32'h0, 4'd0);
    rs1_idx = 5'd4; rs2_idx = 5'd6;
    peek(); expect_rs1("x4 value kept", 1'b0, 32'h11, 4'd0);
    expect_rs2("x6 value kept", 1'b0, 32'h22, 4'd0);
    rs1_idx = 5'd8; rs2_idx = 5'd2;
    peek(); expect_rs1("x8 cleared", 1'b0, 32'h0, 4'd0);
    expect_rs2("x2 cleared", 1'b0, 32'h0, 4'd0);

    rdy = 1'b0; issue = 1'b1; issue_rd = 5'd12; issue_rob_pos = 4'd1;
    reg_write = 1'b1; reg_rd = 5'd12; reg_val = 32'h55; commit_rob_pos = 4'd0; rs1_idx = 5'd12;
    peek(); tick(); idle_inputs();
    peek(); expect_rs1("rdy low frozen", 1'b0, 32'h0, 4'd0);

    rst = 1'b1; rdy = 1'b0; tick(); idle_inputs();
    rs1_idx = 5'd1; rs2_idx = 5'd4;
    peek(); expect_rs1("rst under rdy low x1", 1'b0, 32'h0, 4'd0);
    expect_rs2("rst under rdy low x4", 1'b0, 32'h0, 4'd0);

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rdy       = ($urandom_range(0, 7) != 0);
      rollback  = ($urandom_range(0, 15) == 0);
      issue     = $urandom_range(0, 1);
      issue_rd  = 5'($urandom_range(0, 7));
      issue_rob_pos = 4'($urandom);
      reg_write = $urandom_range(0, 1);
      reg_rd    = 5'($urandom_range(0, 7));
      reg_val   = $urandom;
      commit_rob_pos = $urandom_range(0, 1) ? m_prod[reg_rd] : 4'($urandom);
      rs1_idx   = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2_idx   = $urandom_range(0, 3) == 0 ? rs1_idx : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rs1_idx = reg_rd;
      peek();
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
